// File: rtl/led_scan_pkg.sv
// Shared types and defaults for the LED matrix scan controller.
// Mode and FSM encodings plus default geometry/timing.
package led_scan_pkg;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int DEF_DWELL = 1000;
  localparam int DEF_BLANK = 2;

  typedef enum logic [1:0] {
    MODE_PIX_TEST = 2'b00,
    MODE_PIX_MASK = 2'b01,
    MODE_ROW      = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BLANK = 2'b01,
    ST_DRIVE = 2'b10
  } state_e;

  // 2'b11 falls back to pixel-test.
  function automatic mode_e norm_mode(
    input logic [1:0] m
  );
    mode_e r;
    unique case (m)
      2'b01:   r = MODE_PIX_MASK;
      2'b10:   r = MODE_ROW;
      default: r = MODE_PIX_TEST;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_scan_ctrl_frame_buf.sv
// ROWS x COLS pixel register array, one write port, one comb read.
// Ports: clk, rst_n, wr_en/wr_row/wr_data, rd_row -> rd_data.
module led_frame_buf
  import led_scan_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  localparam int RW  = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_data
);

  logic [ROWS-1:0][COLS-1:0] fb_q;
  logic [ROWS-1:0][COLS-1:0] fb_d;

  always_comb begin
    fb_d = fb_q;
    if (wr_en && (int'(wr_row) < ROWS)) begin
      fb_d[wr_row] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_q <= '0;
    end else begin
      fb_q <= fb_d;
    end
  end

  assign rd_data = fb_q[rd_row];

endmodule

// File: rtl/led_scan_ctrl.sv
// LED matrix scan controller: blank/drive stepping over a frame buffer.
// Ports: clk, rst_n, en, mode, wr_*, led_row/col, cur_row/col, status.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int DWELL = DEF_DWELL,
  parameter int BLANK = DEF_BLANK,
  localparam int RW   = $clog2(ROWS),
  localparam int CLW  = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  output logic [ROWS-1:0] led_row,
  output logic [COLS-1:0] led_col,
  output logic [RW-1:0]   cur_row,
  output logic [CLW-1:0]  cur_col,
  output logic            dwell_valid,
  output logic            frame_start
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNW  = $clog2(CMAX + 1);

  localparam logic [CNW-1:0] DW_LAST = CNW'(DWELL - 1);
  localparam logic [CNW-1:0] BL_LAST =
    CNW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CLW-1:0]  col_q, col_d;
  logic [CNW-1:0]  cnt_q, cnt_d;
  logic [ROWS-1:0] led_row_q, led_row_d;
  logic [COLS-1:0] led_col_q, led_col_d;
  logic            dv_q, dv_d;
  logic            fs_q, fs_d;
  logic            step_done;
  logic            wrap;
  logic            entry;
  logic [COLS-1:0] rd_data;

  led_frame_buf #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_fb (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .rd_row  (row_d),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    step_done = 1'b0;
    wrap      = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      row_d   = '0;
      col_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          mode_d  = norm_mode(mode);
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          state_d = (BLANK == 0) ? ST_DRIVE : ST_BLANK;
        end
        ST_BLANK: begin
          if (cnt_q == BL_LAST) begin
            cnt_d   = '0;
            state_d = ST_DRIVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DW_LAST) begin
            cnt_d     = '0;
            step_done = 1'b1;
            state_d   = (BLANK == 0) ? ST_DRIVE : ST_BLANK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    if (step_done) begin
      if (mode_q == MODE_ROW || col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          wrap = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    // Mode only changes at frame boundaries.
    if (wrap) begin
      row_d  = '0;
      col_d  = '0;
      mode_d = norm_mode(mode);
    end
  end

  // Outputs are registered from next-state so they line up
  // with the state they describe. Column data is captured
  // only on DRIVE entry and then held for the dwell.
  always_comb begin
    entry = (state_d == ST_DRIVE) &&
            ((state_q != ST_DRIVE) || step_done);
    led_row_d = '0;
    led_col_d = '0;
    dv_d      = 1'b0;
    fs_d      = 1'b0;
    if (state_d == ST_DRIVE) begin
      dv_d      = 1'b1;
      led_row_d = ROWS'(1) << row_d;
      if (entry) begin
        fs_d = (row_d == '0) && (col_d == '0);
        unique case (1'b1)
          (mode_d == MODE_ROW):
            led_col_d = rd_data;
          (mode_d == MODE_PIX_MASK):
            led_col_d = rd_data & (COLS'(1) << col_d);
          default:
            led_col_d = COLS'(1) << col_d;
        endcase
      end else begin
        led_col_d = led_col_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_PIX_TEST;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      led_row_q <= '0;
      led_col_q <= '0;
      dv_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      led_row_q <= led_row_d;
      led_col_q <= led_col_d;
      dv_q      <= dv_d;
      fs_q      <= fs_d;
    end
  end

  assign led_row     = led_row_q;
  assign led_col     = led_col_q;
  assign cur_row     = row_q;
  assign cur_col     = col_q;
  assign dwell_valid = dv_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl (4x4, DWELL=3, BLANK=1 and 0).
// Expected values are hand-derived from the scan timing.
module tb_led_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       en0;
  logic [1:0] mode;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [3:0] wr_data;

  logic [3:0] led_row, led_col;
  logic [1:0] cur_row, cur_col;
  logic       dv, fs;

  logic [3:0] b0_led_row, b0_led_col;
  logic [1:0] b0_cur_row, b0_cur_col;
  logic       b0_dv, b0_fs;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_scan_ctrl #(
    .ROWS(4), .COLS(4), .DWELL(3), .BLANK(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .led_row(led_row), .led_col(led_col),
    .cur_row(cur_row), .cur_col(cur_col),
    .dwell_valid(dv), .frame_start(fs)
  );

  led_scan_ctrl #(
    .ROWS(4), .COLS(4), .DWELL(3), .BLANK(0)
  ) u_b0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .led_row(b0_led_row), .led_col(b0_led_col),
    .cur_row(b0_cur_row), .cur_col(b0_cur_col),
    .dwell_valid(b0_dv), .frame_start(b0_fs)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [1:0] r,
    input logic [3:0] d
  );
    wr_en   = 1'b1;
    wr_row  = r;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_fs(input string tag, input int maxc);
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (!fs && i < maxc);
    chk({tag, "_fs"}, 32'(fs), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    en0     = 1'b0;
    mode    = 2'b00;
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_data = '0;
    step();
    step();
    chk("rst_row", 32'(led_row), 32'd0);
    chk("rst_col", 32'(led_col), 32'd0);
    chk("rst_dv",  32'(dv),      32'd0);
    chk("rst_fs",  32'(fs),      32'd0);
    chk("rst_pos", 32'({cur_row, cur_col}), 32'd0);
    rst_n = 1'b1;
    step();
    wr(2'd0, 4'b0110);
    wr(2'd1, 4'b1010);

    // pixel-test
    en = 1'b1;
    step();
    chk("pt_blank_dv",  32'(dv),      32'd0);
    chk("pt_blank_row", 32'(led_row), 32'd0);
    step();
    t0 = cyc;
    chk("pt_row0", 32'(led_row), 32'b0001);
    chk("pt_col0", 32'(led_col), 32'b0001);
    chk("pt_dv0",  32'(dv),      32'd1);
    chk("pt_fs0",  32'(fs),      32'd1);
    step();
    chk("pt_fs1",  32'(fs),      32'd0);
    chk("pt_col1", 32'(led_col), 32'b0001);
    step();
    chk("pt_dv2",  32'(dv),      32'd1);
    step();
    chk("pt_bl_dv", 32'(dv),      32'd0);
    chk("pt_bl_c",  32'(cur_col), 32'd1);
    step();
    chk("pt_s1_col", 32'(led_col), 32'b0010);
    chk("pt_s1_row", 32'(led_row), 32'b0001);
    wait_fs("pt_per", 80);
    chk("pt_period", 32'(cyc - t0), 32'd64);
    t0 = cyc;

    // mode switch at step (1,2)
    for (int i = 0; i < 100; i++) begin
      if (cur_row == 2'd1 && cur_col == 2'd2) break;
      step();
    end
    chk("ms_at12", 32'({cur_row, cur_col}), 32'b0110);
    mode = 2'b10;
    wait_fs("ms", 80);
    chk("ms_period", 32'(cyc - t0), 32'd64);
    chk("rd_r0_col", 32'(led_col), 32'b0110);
    chk("rd_r0_row", 32'(led_row), 32'b0001);
    chk("rd_cc0",    32'(cur_col), 32'd0);
    t0 = cyc;
    repeat (4) step();
    chk("rd_r1_row", 32'(led_row), 32'b0010);
    chk("rd_r1_col", 32'(led_col), 32'b1010);
    chk("rd_r1_cc",  32'(cur_col), 32'd0);
    mode = 2'b01;
    wr(2'd0, 4'b0000);
    wr(2'd1, 4'b0000);
    wr(2'd3, 4'b0000);
    wr(2'd2, 4'b1000);
    wait_fs("rd_per", 20);
    chk("rd_period", 32'(cyc - t0), 32'd16);

    // pixel-masked frame, write coincident with (2,3) latch
    for (int s = 0; s < 16; s++) begin
      int r, c;
      r = s / 4;
      c = s % 4;
      chk("pm_row", 32'(led_row), 32'(1) << r);
      chk("pm_col", 32'(led_col),
          (r == 2 && c == 3) ? 32'h8 : 32'h0);
      repeat (2) step();
      if (s == 11) chk("pm_hold", 32'(led_col), 32'h8);
      step();
      if (s == 10) begin
        wr_en   = 1'b1;
        wr_row  = 2'd2;
        wr_data = 4'b0000;
      end
      step();
      wr_en = 1'b0;
    end
    chk("pm2_fs", 32'(fs), 32'd1);
    repeat (44) step();
    chk("pm2_pos", 32'({cur_row, cur_col}), 32'b1011);
    chk("pm2_row", 32'(led_row), 32'b0100);
    chk("pm2_col", 32'(led_col), 32'd0);

    // abort via en
    en = 1'b0;
    step();
    chk("ab_row", 32'(led_row), 32'd0);
    chk("ab_col", 32'(led_col), 32'd0);
    chk("ab_dv",  32'(dv),      32'd0);
    chk("ab_pos", 32'({cur_row, cur_col}), 32'd0);
    en   = 1'b1;
    mode = 2'b00;
    step();
    chk("ab_bl_dv", 32'(dv), 32'd0);
    step();
    chk("ab_fs",  32'(fs),      32'd1);
    chk("ab_col0", 32'(led_col), 32'b0001);

    // asynchronous reset mid-frame
    repeat (6) step();
    chk("ar_pre_dv", 32'(dv), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_row", 32'(led_row), 32'd0);
    chk("ar_dv",  32'(dv),      32'd0);
    chk("ar_pos", 32'({cur_row, cur_col}), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_bl_dv", 32'(dv), 32'd0);
    step();
    chk("ar_fs",  32'(fs),      32'd1);
    chk("ar_row0", 32'(led_row), 32'b0001);
    chk("ar_col0", 32'(led_col), 32'b0001);
    en = 1'b0;

    // BLANK=0 instance
    en0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) chk("b0_fs", 32'(b0_fs), 32'd1);
      chk("b0_dv",  32'(b0_dv), 32'd1);
      chk("b0_col", 32'(b0_led_col), 32'(1) << (i / 3));
      chk("b0_row", 32'(b0_led_row), 32'b0001);
    end
    step();
    chk("b0_r1", 32'(b0_led_row), 32'b0010);
    chk("b0_c1", 32'(b0_led_col), 32'b0001);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter ROWS, default 8, number of matrix rows (>=2).
REQ-002 Parameter COLS, default 8, number of matrix columns (>=2).
REQ-003 Parameter DWELL, default 1000, drive cycles per scan step (>=1).
REQ-004 Parameter BLANK, default 2, all-off cycles before each drive step (>=0).
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  scan enable.
REQ-008 mode  in  2  00 pixel-test, 01 pixel-masked, 10 row-display, 11 treated as 00.
REQ-009 wr_en  in  1  frame-buffer row write strobe.
REQ-010 wr_row  in  clog2(ROWS)  row address written; addresses >= ROWS are ignored.
REQ-011 wr_data  in  COLS  row pixel data, bit c = column c.
REQ-012 led_row  out  ROWS  one-hot row drive, registered.
REQ-013 led_col  out  COLS  column drive, registered.
REQ-014 cur_row  out  clog2(ROWS)  row index of current step.
REQ-015 cur_col  out  clog2(COLS)  column index of current step (0 in row-display mode).
REQ-016 dwell_valid  out  1  high during every DRIVE cycle.
REQ-017 frame_start  out  1  one-cycle pulse on the first DRIVE cycle of step (0,0).

Function
REQ-018 FSM states: IDLE, BLANK, DRIVE.
REQ-019 IDLE with en=1 -> BLANK, or -> DRIVE if BLANK=0; position (0,0).
REQ-020 BLANK lasts exactly BLANK cycles; led_row=0, led_col=0, dwell_valid=0.
REQ-021 DRIVE lasts exactly DWELL cycles; afterwards position advances and FSM -> BLANK (or DRIVE if BLANK=0).
REQ-022 Pixel modes: steps are row-major, column inner; (ROWS-1,COLS-1) wraps to (0,0); frame = ROWS*COLS steps.
REQ-023 Row-display mode: steps are rows 0..ROWS-1, wrapping to row 0; frame = ROWS steps.
REQ-024 Pixel-test DRIVE: led_row=1<<cur_row, led_col=1<<cur_col regardless of the buffer.
REQ-025 Pixel-masked DRIVE: led_row=1<<cur_row; led_col=(1<<cur_col) when fb[cur_row][cur_col]=1, else 0.
REQ-026 Row-display DRIVE: led_row=1<<cur_row, led_col=fb[cur_row].
REQ-027 Buffer data is latched on entry to DRIVE and held constant for the whole dwell.
REQ-028 A write in the same cycle as the DRIVE latch is not seen; the old data is driven, and the new data is visible on the next visit.
REQ-029 mode is sampled only on leaving IDLE and at frame wrap; a mid-frame change takes effect at the next frame_start.
REQ-030 en=0 in any state -> IDLE on the next edge; outputs zero, position (0,0), dwell counter cleared; no partial dwell is resumed.
REQ-031 Frame period in cycles = steps*(BLANK+DWELL); first DRIVE cycle occurs BLANK+1 edges after en is sampled high.
REQ-032 wr_en writes wr_data to fb[wr_row] on the edge, in any state.

Reset
REQ-033 rst_n low: state IDLE, all outputs 0, position (0,0), counters 0, sampled mode 00, frame buffer all 0.
REQ-034 Reset asserted mid-frame takes effect immediately, without waiting for a clock edge.
REQ-035 After release, scanning restarts from (0,0) with a fresh BLANK.

Structure
REQ-036 Shared package led_scan_pkg: mode encodings, FSM state encodings, and default ROWS/COLS/DWELL/BLANK.
REQ-037 One sub-module, led_frame_buf: ROWS x COLS register array with one write port and one combinational read port.

Verification (ROWS=4, COLS=4, DWELL=3, BLANK=1 unless stated)
REQ-038 Pixel-test:
- Stimulus: mode 00, en=1.
- Response: step (0,0) drives led_row=0001, led_col=0001 for 3 cycles after 1 blank cycle; step 1 drives led_col=0010; frame_start every 64 cycles.
REQ-039 Row-display:
- Stimulus: write row1=1010, mode 10.
- Response: row-1 step drives led_row=0010, led_col=1010; frame_start every 16 cycles.
REQ-040 Pixel-masked:
- Stimulus: only fb[2][3]=1.
- Response: led_col=1000 only at step (2,3); at all other steps led_col=0 while led_row is still one-hot.
REQ-041 Mode switch:
- Stimulus: 00 -> 10 at step (1,2).
- Response: pixel scan completes the frame; the next frame_start begins row-display.
REQ-042 Abort:
- Stimulus: en dropped mid-DRIVE, then rst_n pulsed mid-frame.
- Response: outputs 0 on the next edge or immediately, respectively; restart at (0,0) after BLANK.
REQ-043 BLANK=0:
- Stimulus: mode 00, en=1 with BLANK=0.
- Response: dwell_valid is continuously high; steps are exactly 3 cycles apart.
